lsu_unit: RTL and testbench
===========================

Name: lsu_unit

Overview:
- Load/store unit directly downstream of the main decoder in the RISC-V core.
- Consumes MemWrite, ResultSrc, Store[1:0] and Load[2:0], plus the ALU-computed address and the rs2 store data.
- Drives a word-wide data memory through a req/ack handshake with arbitrary wait states.
- Stalls the core until the access completes, and returns sign- or zero-extended load data for the ResultSrc=01 path.

Parameters:
- TIMEOUT_CYC, 255: BUSY cycles without mem_ack before timeout_err fires. Used only when LSU_TIMEOUT_EN is defined.
- ADDR_W, 32: width of the address bus.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemWrite  in  1  store request from the decoder.
- ResultSrc  in  2  value 01 means a load request.
- Store  in  2  00 sw, 01 sh, 10 sb.
- Load  in  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu; codes 101–111 are handled as lw.
- addr  in  ADDR_W  byte address from the ALU.
- wdata  in  32  store data (rs2).
- rdata  out  32  extended load result; valid while done=1.
- done  out  1  one-cycle pulse when the access retires.
- stall  out  1  core must hold PC and all LSU inputs steady while this is 1.
- misalign_err  out  1  one-cycle pulse that coincides with done.
- timeout_err  out  1  one-cycle pulse that coincides with done. Always 0 without LSU_TIMEOUT_EN.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word-aligned address (addr with bits [1:0] forced to 0).
- mem_wstrb  out  4  byte-lane write enables.
- mem_wdata  out  32  lane-positioned store data.
- mem_rdata  in  32  read word; valid in the same cycle as mem_ack.
- mem_ack  in  1  memory completion; 1-cycle pulse.

Behaviour:
- Reset: rst_n=0 asynchronously forces the state machine to IDLE, regardless of any access in progress.
  - All registered outputs go to 0: mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, rdata, done, misalign_err, timeout_err.
  - stall is also forced to 0 during reset.
  - mem_req drops immediately on reset, even mid-access. The memory side tolerates an abandoned request.
- Access detection:
  - Load request: ld = (ResultSrc==01).
  - Active operation: op = MemWrite | ld.
  - If MemWrite and ld are both 1, the access is treated as a store.
- stall (combinational) = (state==IDLE & op) | (state==BUSY).
  - stall is 0 in DONE, so the core advances on the DONE clock edge.
- Misalignment rules:
  - lw/sw: misaligned if addr[1:0]!=0.
  - lh/lhu/sh: misaligned if addr[0]!=0.
  - Byte accesses are never misaligned.
- State machine (states IDLE, BUSY, DONE):
  - IDLE, op=1, aligned: register mem_addr, mem_we, mem_wstrb and mem_wdata; set mem_req=1; go to BUSY.
  - IDLE, op=1, misaligned: no memory request; go to DONE with misalign_err=1 and rdata=0.
  - IDLE, op=0: stay in IDLE.
  - BUSY, mem_ack=1: clear mem_req and mem_wstrb; for a read, capture the extended mem_rdata into rdata; go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. A back-to-back memory op is detected in that following IDLE cycle.
- Latency:
  - Minimum 3 cycles from op assertion to retire (IDLE, BUSY with immediate ack, DONE).
  - Each memory wait state adds 1 cycle.
  - A misaligned access takes 2 cycles.
- Store byte lanes:
  - sb: mem_wstrb = 0001<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - sh: mem_wstrb = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - sw: mem_wstrb = 1111; mem_wdata = wdata.
  - Loads drive mem_wstrb = 0000.
- Load extraction:
  - Byte select = mem_rdata >> (8*addr[1:0]); halfword select = mem_rdata >> (16*addr[1]).
  - lb and lh sign-extend from bit 7 and bit 15 respectively.
  - lbu and lhu zero-extend.
  - rdata holds its value until the next load retires. A store retirement does not change rdata.
- mem_ack outside BUSY is ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN, when defined:
  - An 8+-bit counter clears on entry to BUSY and increments each BUSY cycle without mem_ack.
  - When the counter reaches TIMEOUT_CYC, the unit drops mem_req, goes to DONE with timeout_err=1, and sets rdata=0 for a load.
  - If mem_ack and the terminal count occur in the same cycle, the ack wins and timeout_err stays 0.
- When undefined:
  - No counter is present and timeout_err is tied to 0.
  - BUSY waits indefinitely for mem_ack.

Test Plan:
1. lw at addr 0x104, mem_rdata=0xDEADBEEF, ack after 2 wait states -> mem_addr=0x104, mem_we=0; stall high for 4 cycles; done with rdata=0xDEADBEEF.
2. lb at addr 0x103, mem_rdata=0x80112233 -> rdata=0xFFFFFF80. Same access as lbu -> rdata=0x00000080.
3. sh at addr 0x22, wdata=0x0000ABCD, immediate ack -> mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1; done on the 3rd cycle.
4. lw at addr 0x101 -> no mem_req; misalign_err and done pulse together in cycle 2; rdata=0.
5. rst_n driven low during BUSY while mem_req=1 -> mem_req=0 and stall=0 immediately; after release the unit idles in IDLE. Next, sb at 0x41 with wdata=0x5A -> mem_wstrb=0010, mem_wdata=0x5A5A5A5A.
6. With LSU_TIMEOUT_EN and TIMEOUT_CYC=4, lw with mem_ack never asserted -> timeout_err and done after 4 BUSY cycles; mem_req drops; the next access proceeds normally.

Source files
------------

// File: rtl/lsu_unit.sv
// Load/store unit: decodes core memory ops, drives a req/ack word memory, stalls until retire.
// Optional access timeout is compiled in with `define LSU_TIMEOUT_EN.
module lsu_unit #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemWrite,
    input  logic [1:0]        ResultSrc,
    input  logic [1:0]        Store,
    input  logic [2:0]        Load,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              stall,
    output logic              misalign_err,
    output logic              timeout_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
    typedef enum logic [2:0] {LD_B, LD_H, LD_W, LD_BU, LD_HU} ld_kind_e;

    state_e            state_q;
    ld_kind_e          ld_kind_q;
    logic [1:0]        off_q;
    logic              is_load_q;
    logic [31:0]       rdata_q;
    logic              done_q;
    logic              misalign_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_wstrb_q;
    logic [31:0]       mem_wdata_q;

    logic              ld;
    logic              op;
    size_e             size_d;
    ld_kind_e          ld_kind_d;
    logic              misaligned;
    logic [3:0]        wstrb_d;
    logic [31:0]       wdata_d;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       ext_rdata;

    assign ld = (ResultSrc == 2'b01);
    assign op = MemWrite | ld;

    // A simultaneous MemWrite and load request is resolved as a store.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ld_kind_d = LD_W;
        size_d    = SZ_W;
        case (Load)
            3'b000:  ld_kind_d = LD_B;
            3'b001:  ld_kind_d = LD_H;
            3'b011:  ld_kind_d = LD_BU;
            3'b100:  ld_kind_d = LD_HU;
            default: ld_kind_d = LD_W;
        endcase
        if (MemWrite) begin
            case (Store)
                2'b01:   size_d = SZ_H;
                2'b10:   size_d = SZ_B;
                default: size_d = SZ_W;
            endcase
        end else begin
            case (ld_kind_d)
                LD_B, LD_BU: size_d = SZ_B;
                LD_H, LD_HU: size_d = SZ_H;
                default:     size_d = SZ_W;
            endcase
        end
    end

    always_comb begin
        misaligned = 1'b0;
        wstrb_d    = 4'b1111;
        wdata_d    = wdata;
        case (size_d)
            SZ_B: begin
                wstrb_d = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            SZ_H: begin
                misaligned = addr[0];
                wstrb_d    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{wdata[15:0]}};
            end
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (off_q)
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_kind_q)
            LD_B:    ext_rdata = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ext_rdata = {24'h0, byte_sel};
            LD_H:    ext_rdata = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ext_rdata = {16'h0, half_sel};
            default: ext_rdata = mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ld_kind_q   <= LD_W;
            off_q       <= 2'b00;
            is_load_q   <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (op) begin
                        ld_kind_q <= ld_kind_d;
                        off_q     <= addr[1:0];
                        is_load_q <= ~MemWrite;
                        if (misaligned) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                            if (!MemWrite) rdata_q <= '0;
                        end else begin
                            state_q     <= S_BUSY;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= MemWrite;
                            mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_wstrb_q <= MemWrite ? wstrb_d : 4'b0000;
                            mem_wdata_q <= MemWrite ? wdata_d : 32'h0;
`ifdef LSU_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                        end
                    end
                end
                S_BUSY: begin
                    // An ack in the terminal-count cycle takes priority over the timeout.
                    if (mem_ack) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        mem_req_q   <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        if (is_load_q) rdata_q <= ext_rdata;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        timeout_q   <= 1'b1;
                        mem_req_q   <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        if (is_load_q) rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall        = rst_n & (((state_q == S_IDLE) & op) | (state_q == S_BUSY));
    assign rdata        = rdata_q;
    assign done         = done_q;
    assign misalign_err = misalign_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: scripted accesses, cycle-level expectation model, negedge compare.
// The timeout scenario is included when LSU_TIMEOUT_EN is defined.
module tb_lsu_unit;

    localparam int TO_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  Store;
    logic [2:0]  Load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        stall;
    logic        misalign_err;
    logic        timeout_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    lsu_unit #(.TIMEOUT_CYC(TO_CYC), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
        .Store(Store), .Load(Load), .addr(addr), .wdata(wdata), .rdata(rdata),
        .done(done), .stall(stall), .misalign_err(misalign_err), .timeout_err(timeout_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected state for the current cycle, written by the driver.
    logic        chk_en = 1'b0;
    logic        exp_stall = 1'b0, exp_req = 1'b0, exp_done = 1'b0;
    logic        exp_mis = 1'b0, exp_to = 1'b0, exp_we = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
    logic [3:0]  exp_wstrb = '0;
    int          stall_cycles = 0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] last_wdata = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", {31'b0, stall}, {31'b0, exp_stall});
            check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
            check("done", {31'b0, done}, {31'b0, exp_done});
            check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_done & exp_mis});
            check("timeout_err", {31'b0, timeout_err}, {31'b0, exp_done & exp_to});
            if (exp_req) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
                check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_wstrb});
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
                last_wstrb = mem_wstrb;
                last_wdata = mem_wdata;
            end
            if (exp_done) check("rdata", rdata, exp_rdata);
            if (stall) stall_cycles++;
        end
    end

    function automatic int access_bytes(input logic we, input logic [1:0] st, input logic [2:0] ld);
        if (we) return (st == 2'b01) ? 2 : (st == 2'b10) ? 1 : 4;
        if (ld == 3'd0 || ld == 3'd3) return 1;
        if (ld == 3'd1 || ld == 3'd4) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] ld, input logic [31:0] a, input logic [31:0] w);
        int unsigned b = (w >> (8 * (a % 4))) & 32'hFF;
        int unsigned h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (ld)
            3'd0:    return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
            3'd3:    return 32'(b);
            3'd4:    return 32'(h);
            default: return w;
        endcase
    endfunction

    // One access from IDLE to retire; returns right after the DONE cycle's inputs are settled.
    task automatic access(input logic we, input logic [1:0] rs, input logic [1:0] st, input logic [2:0] ld,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                          input int waits, input bit no_ack);
        int nb = access_bytes(we, st, ld);
        bit mis = (a % nb) != 0;
        int unsigned mask = (nb == 4) ? 32'hFFFF_FFFF : (nb == 2) ? 32'hFFFF : 32'hFF;
        int unsigned rep = (nb == 4) ? 1 : (nb == 2) ? 32'h0001_0001 : 32'h0101_0101;
        int n_busy = no_ack ? TO_CYC : waits + 1;
        @(posedge clk); #1;
        MemWrite = we; ResultSrc = rs; Store = st; Load = ld; addr = a; wdata = wd; mem_ack = 1'b0;
        stall_cycles = 0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0;
        exp_we = we; exp_addr = a & 32'hFFFF_FFFC;
        exp_wstrb = we ? 4'(((1 << nb) - 1) << (a % 4)) : 4'b0000;
        exp_wdata = 32'((wd & mask) * rep);
        if (!mis) begin
            for (int i = 0; i < n_busy; i++) begin
                @(posedge clk); #1;
                exp_stall = 1'b1; exp_req = 1'b1; exp_done = 1'b0;
                if (!no_ack && i == n_busy - 1) begin
                    mem_ack = 1'b1; mem_rdata = rword;
                end else begin
                    mem_ack = 1'b0; mem_rdata = 32'h0BAD_F00D ^ 32'(i);
                end
            end
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'hA5A5_A5A5;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b1;
        exp_mis = mis; exp_to = no_ack && !mis;
        if (!we) exp_rdata = (mis || no_ack) ? 32'h0 : load_model(ld, a, rword);
    endtask

    task automatic idle_cycles(input int n, input bit ack_noise);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            MemWrite = 1'b0; ResultSrc = 2'b00; mem_ack = ack_noise; mem_rdata = 32'hFFFF_FFFF;
            exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; MemWrite = 1'b0; ResultSrc = 2'b00; Store = 2'b00; Load = 3'b000;
        addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        #2;
        check("reset mem_req", {31'b0, mem_req}, 32'h0);
        check("reset stall", {31'b0, stall}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        check("reset rdata", rdata, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
        #10 rst_n = 1'b1;
        chk_en = 1'b1;
        idle_cycles(1, 1'b0);

        // lw 0x104 with two wait states
        access(1'b0, 2'b01, 2'b00, 3'b010, 32'h104, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
        check("t1 stall cycles", 32'(stall_cycles), 32'd4);
        check("t1 rdata", rdata, 32'hDEAD_BEEF);
        // lb / lbu at 0x103
        access(1'b0, 2'b01, 2'b00, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 0, 1'b0);
        check("t2 lb rdata", rdata, 32'hFFFF_FF80);
        access(1'b0, 2'b01, 2'b00, 3'b011, 32'h103, 32'h0, 32'h8011_2233, 1, 1'b0);
        check("t2 lbu rdata", rdata, 32'h0000_0080);
        // sh 0x22 immediate ack; rdata must survive the store
        access(1'b1, 2'b00, 2'b01, 3'b000, 32'h22, 32'h0000_ABCD, 32'h0, 0, 1'b0);
        check("t3 stall cycles", 32'(stall_cycles), 32'd2);
        check("t3 wstrb", {28'b0, last_wstrb}, 32'hC);
        check("t3 wdata", last_wdata, 32'hABCD_ABCD);
        check("t3 rdata kept", rdata, 32'h0000_0080);
        // lw misaligned
        access(1'b0, 2'b01, 2'b00, 3'b010, 32'h101, 32'h0, 32'h1234_5678, 0, 1'b0);
        check("t4 stall cycles", 32'(stall_cycles), 32'd1);
        check("t4 rdata", rdata, 32'h0);
        // halfword loads, code 111 treated as lw, sw, store-wins overlap
        access(1'b0, 2'b01, 2'b00, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 0, 1'b0);
        check("lh rdata", rdata, 32'hFFFF_8001);
        access(1'b0, 2'b01, 2'b00, 3'b100, 32'h100, 32'h0, 32'h1234_F00F, 3, 1'b0);
        check("lhu rdata", rdata, 32'h0000_F00F);
        access(1'b0, 2'b01, 2'b00, 3'b111, 32'h108, 32'h0, 32'hCAFE_0001, 0, 1'b0);
        check("load code 111 rdata", rdata, 32'hCAFE_0001);
        access(1'b1, 2'b00, 2'b00, 3'b000, 32'h300, 32'h1234_5678, 32'h0, 1, 1'b0);
        check("sw wstrb", {28'b0, last_wstrb}, 32'hF);
        access(1'b1, 2'b01, 2'b10, 3'b010, 32'h43, 32'h0000_00C3, 32'h0, 0, 1'b0);
        check("store-wins wstrb", {28'b0, last_wstrb}, 32'h8);
        check("store-wins rdata kept", rdata, 32'hCAFE_0001);
        access(1'b0, 2'b01, 2'b00, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1'b0);
        check("lh misaligned rdata", rdata, 32'h0);
        // stray ack while idle must be ignored
        idle_cycles(3, 1'b1);
        check("idle ack rdata", rdata, 32'h0);

        // reset in the middle of a BUSY access
        @(posedge clk); #1;
        MemWrite = 1'b0; ResultSrc = 2'b01; Load = 3'b010; addr = 32'h200; mem_ack = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_done = 1'b0;
        @(posedge clk); #1;
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h200; exp_wstrb = 4'b0000;
        #2;
        check("t5 mem_req before reset", {31'b0, mem_req}, 32'h1);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5 mem_req in reset", {31'b0, mem_req}, 32'h0);
        check("t5 stall in reset", {31'b0, stall}, 32'h0);
        #7;
        ResultSrc = 2'b00;
        rst_n = 1'b1;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_rdata = 32'h0;
        chk_en = 1'b1;
        idle_cycles(2, 1'b0);
        access(1'b1, 2'b00, 2'b10, 3'b000, 32'h41, 32'h0000_005A, 32'h0, 0, 1'b0);
        check("t5 sb wstrb", {28'b0, last_wstrb}, 32'h2);
        check("t5 sb wdata", last_wdata, 32'h5A5A_5A5A);

`ifdef LSU_TIMEOUT_EN
        access(1'b0, 2'b01, 2'b00, 3'b010, 32'h400, 32'h0, 32'h0, 0, 1'b1);
        check("t6 stall cycles", 32'(stall_cycles), 32'd5);
        check("t6 rdata", rdata, 32'h0);
        access(1'b0, 2'b01, 2'b00, 3'b010, 32'h404, 32'h0, 32'h7654_3210, 1, 1'b0);
        check("t6 next rdata", rdata, 32'h7654_3210);
`endif
        idle_cycles(2, 1'b0);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
